// File: rtl/ts_event_scheduler_if.sv
// rtl/ts_event_scheduler_if.sv - client, timestamper and record-consume signals of ts_event_scheduler
interface ts_event_scheduler_if #(
   parameter int N_CLIENTS = 4,
   parameter int ID_W      = 4
);
   logic [N_CLIENTS-1:0]      cl_start_valid;
   logic [N_CLIENTS-1:0]      cl_start_ready;
   logic [ID_W-1:0]           cl_alloc_id;
   logic [N_CLIENTS-1:0]      cl_end_valid;
   logic [N_CLIENTS*ID_W-1:0] cl_end_id;
   logic [N_CLIENTS-1:0]      cl_end_ready;
   logic                      ts_start_valid;
   logic                      ts_start_ready;
   logic [ID_W-1:0]           ts_start_id;
   logic                      ts_end_valid;
   logic                      ts_end_ready;
   logic [ID_W-1:0]           ts_end_id;
   logic                      rec_fire;
   logic [ID_W-1:0]           rec_id;
   logic [ID_W:0]             free_cnt;
   logic [2:0]                err_sticky;

   modport master (
      output cl_start_valid, cl_end_valid, cl_end_id, ts_start_ready, ts_end_ready, rec_fire, rec_id,
      input  cl_start_ready, cl_alloc_id, cl_end_ready, ts_start_valid, ts_start_id,
             ts_end_valid, ts_end_id, free_cnt, err_sticky
   );

   modport slave (
      input  cl_start_valid, cl_end_valid, cl_end_id, ts_start_ready, ts_end_ready, rec_fire, rec_id,
      output cl_start_ready, cl_alloc_id, cl_end_ready, ts_start_valid, ts_start_id,
             ts_end_valid, ts_end_id, free_cnt, err_sticky
   );
endinterface

// File: rtl/ts_event_scheduler.sv
// rtl/ts_event_scheduler.sv - event-ID pool owner and round-robin start/end arbiter for the timestamper
// Optional build macro TS_SCHED_PRIO_EN: client 0 gets strict priority on both arbiters.
module ts_event_scheduler #(
   parameter int N_CLIENTS = 4,
   parameter int ID_W      = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   ts_event_scheduler_if.slave bus
);
   localparam int POOL = 1 << ID_W;
   localparam int PW   = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
   localparam logic [ID_W:0]  POOL_CNT = {1'b1, {ID_W{1'b0}}};
   localparam logic [PW-1:0]  LAST     = PW'(N_CLIENTS - 1);

   typedef enum logic {S_IDLE, S_ISSUE} s_state_t;
   typedef enum logic [1:0] {E_IDLE, E_ISSUE, E_DROP} e_state_t;

   s_state_t        s_state;
   e_state_t        e_state;
   logic [POOL-1:0] alloc, started, ended;
   logic [PW-1:0]   s_ptr, e_ptr, s_owner, e_owner;
   logic [ID_W-1:0] s_id, e_id, free_id, e_req_id;
   logic [ID_W:0]   free_cnt;
   logic [2:0]      err;
   logic            ts_start_valid, ts_end_valid;
   logic [PW:0]     s_pick, e_pick;
   logic            s_grant, s_hs, e_grant, e_ok, e_unstarted, e_hs, e_ack, do_free;

   // Returns {found, index}: first requester at or after ptr, wrapping around.
   function automatic logic [PW:0] rr_pick(input logic [N_CLIENTS-1:0] req, input logic [PW-1:0] ptr);
      logic [N_CLIENTS-1:0] rot;
      logic [PW:0]          idx;
      logic [PW:0]          res;
      rot = N_CLIENTS'({req, req} >> ptr);
      res = '0;
      for (int i = N_CLIENTS - 1; i >= 0; i--) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(N_CLIENTS)) idx = idx - (PW+1)'(N_CLIENTS);
         if (rot[i]) res = {1'b1, idx[PW-1:0]};
      end
      return res;
   endfunction

   function automatic logic [PW:0] arb(input logic [N_CLIENTS-1:0] req, input logic [PW-1:0] ptr);
`ifdef TS_SCHED_PRIO_EN
      if (req[0]) return {1'b1, {PW{1'b0}}};
      return rr_pick(req & ~{{(N_CLIENTS-1){1'b0}}, 1'b1}, ptr);
`else
      return rr_pick(req, ptr);
`endif
   endfunction

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] k);
      return (k == LAST) ? '0 : k + 1'b1;
   endfunction

   assign s_pick      = arb(bus.cl_start_valid, s_ptr);
   assign e_pick      = arb(bus.cl_end_valid, e_ptr);
   assign s_grant     = (s_state == S_IDLE) && s_pick[PW] && (free_cnt != '0);
   assign s_hs        = (s_state == S_ISSUE) && bus.ts_start_ready;
   assign e_grant     = (e_state == E_IDLE) && e_pick[PW];
   assign e_unstarted = !alloc[e_req_id] || !started[e_req_id];
   assign e_ok        = !e_unstarted && !ended[e_req_id];
   assign e_hs        = (e_state == E_ISSUE) && bus.ts_end_ready;
   assign e_ack       = e_hs || (e_state == E_DROP);
   assign do_free     = bus.rec_fire && alloc[bus.rec_id] && ended[bus.rec_id];

   always_comb begin
      free_id = '0;
      for (int i = POOL - 1; i >= 0; i--)
         if (!alloc[i]) free_id = ID_W'(i);
      e_req_id = '0;
      for (int k = 0; k < N_CLIENTS; k++)
         if (e_pick[PW-1:0] == PW'(k)) e_req_id = bus.cl_end_id[k*ID_W +: ID_W];
   end

   always_comb begin
      bus.cl_start_ready = '0;
      bus.cl_end_ready   = '0;
      for (int k = 0; k < N_CLIENTS; k++) begin
         bus.cl_start_ready[k] = s_hs && (s_owner == PW'(k));
         bus.cl_end_ready[k]   = e_ack && (e_owner == PW'(k));
      end
   end

   assign bus.cl_alloc_id    = s_hs ? s_id : '0;
   assign bus.ts_start_valid = ts_start_valid;
   assign bus.ts_start_id    = s_id;
   assign bus.ts_end_valid   = ts_end_valid;
   assign bus.ts_end_id      = e_id;
   assign bus.free_cnt       = free_cnt;
   assign bus.err_sticky     = err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_state        <= S_IDLE;
         e_state        <= E_IDLE;
         alloc          <= '0;
         started        <= '0;
         ended          <= '0;
         s_ptr          <= '0;
         e_ptr          <= '0;
         s_owner        <= '0;
         e_owner        <= '0;
         s_id           <= '0;
         e_id           <= '0;
         free_cnt       <= POOL_CNT;
         err            <= '0;
         ts_start_valid <= 1'b0;
         ts_end_valid   <= 1'b0;
      end else begin
         // Allocation reads the pre-free pool, so a freed ID is reusable one cycle later.
         free_cnt <= free_cnt + {{ID_W{1'b0}}, do_free} - {{ID_W{1'b0}}, s_grant};
         if (s_grant)          alloc[free_id]   <= 1'b1;
         if (s_hs)             started[s_id]    <= 1'b1;
         if (e_grant && e_ok)  ended[e_req_id]  <= 1'b1;
         if (do_free) begin
            alloc[bus.rec_id]   <= 1'b0;
            started[bus.rec_id] <= 1'b0;
            ended[bus.rec_id]   <= 1'b0;
         end
         if (e_grant && !e_ok) begin
            if (e_unstarted) err[0] <= 1'b1;
            else             err[1] <= 1'b1;
         end
         if (bus.rec_fire && !do_free) err[2] <= 1'b1;

         case (s_state)
            S_IDLE: if (s_grant) begin
               s_state        <= S_ISSUE;
               s_owner        <= s_pick[PW-1:0];
               s_id           <= free_id;
               ts_start_valid <= 1'b1;
`ifdef TS_SCHED_PRIO_EN
               if (s_pick[PW-1:0] != '0) s_ptr <= nxt(s_pick[PW-1:0]);
`else
               s_ptr <= nxt(s_pick[PW-1:0]);
`endif
            end
            S_ISSUE: if (bus.ts_start_ready) begin
               s_state        <= S_IDLE;
               ts_start_valid <= 1'b0;
            end
         endcase

         case (e_state)
            E_IDLE: if (e_grant) begin
               e_owner <= e_pick[PW-1:0];
`ifdef TS_SCHED_PRIO_EN
               if (e_pick[PW-1:0] != '0) e_ptr <= nxt(e_pick[PW-1:0]);
`else
               e_ptr <= nxt(e_pick[PW-1:0]);
`endif
               if (e_ok) begin
                  e_state      <= E_ISSUE;
                  e_id         <= e_req_id;
                  ts_end_valid <= 1'b1;
               end else begin
                  e_state <= E_DROP;
               end
            end
            E_ISSUE: if (bus.ts_end_ready) begin
               e_state      <= E_IDLE;
               ts_end_valid <= 1'b0;
            end
            E_DROP:  e_state <= E_IDLE;
            default: e_state <= E_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ts_event_scheduler.sv
// tb/tb_ts_event_scheduler.sv - randomized scoreboard bench for ts_event_scheduler against a pool/queue model
module tb_ts_event_scheduler;
   localparam int N    = 4;
   localparam int IW   = 4;
   localparam int POOL = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ts_event_scheduler_if #(.N_CLIENTS(N), .ID_W(IW)) bus ();
   ts_event_scheduler #(.N_CLIENTS(N), .ID_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;

   // Model: per-ID lifecycle 0=free 1=started 2=ended, pointers = next client to favour
   int         m_st[POOL];
   int         m_free, m_sptr, m_eptr;
   logic [2:0] m_err;
   int exp_s_cl[$], exp_s_id[$], exp_e_cl[$], exp_e_fwd[$], exp_e_id[$];
   int order_q[$], live_q[$], ended_q[$];
   int ids[4];
   int mon_c, mon_id, mon_f;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < POOL; i++) m_st[i] = 0;
      m_free = POOL; m_sptr = 0; m_eptr = 0; m_err = 3'b000;
      exp_s_cl.delete(); exp_s_id.delete();
      exp_e_cl.delete(); exp_e_fwd.delete(); exp_e_id.delete();
   endtask

   task automatic rr_fill(input logic [3:0] set, input int ptr);
      order_q.delete();
      for (int i = 0; i < N; i++) begin
         int c;
         c = (ptr + i) % N;
         if ((set & (4'd1 << c)) != 0) order_q.push_back(c);
      end
   endtask

   function automatic int lowest_free();
      for (int i = 0; i < POOL; i++) if (m_st[i] == 0) return i;
      return -1;
   endfunction

   task automatic collect();
      live_q.delete(); ended_q.delete();
      for (int i = 0; i < POOL; i++) begin
         if (m_st[i] == 1) live_q.push_back(i);
         if (m_st[i] == 2) ended_q.push_back(i);
      end
   endtask

   task automatic drive_idle();
      bus.cl_start_valid = '0; bus.cl_end_valid = '0; bus.cl_end_id = '0;
      bus.ts_start_ready = 1'b0; bus.ts_end_ready = 1'b0;
      bus.rec_fire = 1'b0; bus.rec_id = '0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      drive_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Whole request set asserted at once and held; rdy_mode 1 means ts_start_ready tied high.
   task automatic run_start(input logic [3:0] set, input int rdy_mode);
      logic [3:0] pend;
      int it, nack;
      rr_fill(set, m_sptr);
      foreach (order_q[j]) begin
         int id;
         id = lowest_free();
         m_st[id] = 1; m_free--;
         exp_s_cl.push_back(order_q[j]); exp_s_id.push_back(id);
         m_sptr = (order_q[j] + 1) % N;
      end
      pend = set; it = 0; nack = 0;
      bus.cl_start_valid = pend;
      bus.ts_start_ready = (rdy_mode == 1) || ($urandom_range(0, 1) == 1);
      while (pend != 0 && it < 200) begin
         @(negedge clk);
         if (bus.cl_start_ready != 0) begin
            if (rdy_mode == 1) chk("start_spacing", it, 2 * nack + 1);
            nack++;
         end
         pend &= ~bus.cl_start_ready;
         @(posedge clk); #1;
         it++;
         bus.cl_start_valid = pend;
         bus.ts_start_ready = (rdy_mode == 1) || ($urandom_range(0, 1) == 1);
      end
      chk("start_done", pend, 0);
      bus.ts_start_ready = 1'b0;
   endtask

   // rdy_mode: 0 random, 1 always ready, 2 ready held low for five issue cycles
   task automatic run_end(input logic [3:0] set, input int eids[4], input int rdy_mode);
      logic [3:0] pend;
      int it, hold_id;
      rr_fill(set, m_eptr);
      hold_id = -1;
      foreach (order_q[j]) begin
         int c, id, fwd;
         c = order_q[j]; id = eids[c]; fwd = 0;
         if (m_st[id] == 1) begin
            fwd = 1; m_st[id] = 2;
            if (hold_id < 0) hold_id = id;
         end else if (m_st[id] == 0) m_err[0] = 1'b1;
         else m_err[1] = 1'b1;
         exp_e_cl.push_back(c); exp_e_fwd.push_back(fwd); exp_e_id.push_back(id);
         m_eptr = (c + 1) % N;
      end
      pend = set; it = 0;
      bus.cl_end_id    = {IW'(eids[3]), IW'(eids[2]), IW'(eids[1]), IW'(eids[0])};
      bus.cl_end_valid = pend;
      bus.ts_end_ready = (rdy_mode == 1) || (rdy_mode == 0 && $urandom_range(0, 1) == 1);
      while (pend != 0 && it < 200) begin
         @(negedge clk);
         if (rdy_mode == 2 && it >= 1 && it <= 5) begin
            chk("end_hold_valid", bus.ts_end_valid, 1);
            chk("end_hold_id", bus.ts_end_id, hold_id);
         end
         pend &= ~bus.cl_end_ready;
         @(posedge clk); #1;
         it++;
         bus.cl_end_valid = pend;
         bus.ts_end_ready = (rdy_mode == 1) || (rdy_mode == 2 && it >= 6) ||
                            (rdy_mode == 0 && $urandom_range(0, 1) == 1);
      end
      chk("end_done", pend, 0);
      bus.ts_end_ready = 1'b0;
   endtask

   task automatic do_free(input int id);
      if (m_st[id] == 2) begin m_st[id] = 0; m_free++; end
      else m_err[2] = 1'b1;
      bus.rec_fire = 1'b1; bus.rec_id = IW'(id);
      @(posedge clk); #1;
      bus.rec_fire = 1'b0;
   endtask

   task automatic phase_check();
      @(negedge clk);
      chk("free_cnt", bus.free_cnt, m_free);
      chk("err_sticky", bus.err_sticky, m_err);
      @(posedge clk); #1;
   endtask

   function automatic logic [3:0] pick_set(input int limit);
      logic [3:0] s;
      s = 4'($urandom_range(1, 15));
      while ($countones(s) > limit) s = s & (s - 4'd1);
      return s;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.cl_start_ready != 0) begin
            if (exp_s_cl.size() == 0) chk("start_unexpected", bus.cl_start_ready, 0);
            else begin
               mon_c = exp_s_cl.pop_front(); mon_id = exp_s_id.pop_front();
               chk("start_client", bus.cl_start_ready, 4'd1 << mon_c);
               chk("start_alloc_id", bus.cl_alloc_id, mon_id);
               chk("start_ts_id", bus.ts_start_id, mon_id);
               chk("start_ts_hs", bus.ts_start_valid && bus.ts_start_ready, 1);
            end
         end
         if (bus.cl_end_ready != 0) begin
            if (exp_e_cl.size() == 0) chk("end_unexpected", bus.cl_end_ready, 0);
            else begin
               mon_c = exp_e_cl.pop_front(); mon_f = exp_e_fwd.pop_front(); mon_id = exp_e_id.pop_front();
               chk("end_client", bus.cl_end_ready, 4'd1 << mon_c);
               chk("end_forwarded", bus.ts_end_valid && bus.ts_end_ready, mon_f);
               if (mon_f == 1) chk("end_ts_id", bus.ts_end_id, mon_id);
            end
         end
      end
   end

   initial begin
      int it, got, r, id;
      rst_n = 1'b0;
      drive_idle();
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_free_cnt", bus.free_cnt, 16);
      chk("rst_err", bus.err_sticky, 0);
      chk("rst_ts_start_valid", bus.ts_start_valid, 0);
      chk("rst_ts_end_valid", bus.ts_end_valid, 0);
      chk("rst_cl_start_ready", bus.cl_start_ready, 0);
      chk("rst_cl_end_ready", bus.cl_end_ready, 0);
      chk("rst_alloc_id", bus.cl_alloc_id, 0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_start(4'b0010, 1);
      phase_check();

      apply_reset();
      run_start(4'b1111, 1);
      run_start(4'b0001, 1);
      phase_check();

      ids = '{9, 9, 9, 9};
      run_end(4'b0100, ids, 1);
      phase_check();
      ids = '{3, 0, 0, 0};
      run_end(4'b0001, ids, 2);
      phase_check();
      ids = '{0, 3, 0, 0};
      run_end(4'b0010, ids, 1);
      phase_check();

      while (m_free > 0) run_start(pick_set(m_free), 0);
      phase_check();

      bus.ts_start_ready = 1'b1;
      bus.cl_start_valid = 4'b0010;
      repeat (8) begin
         @(negedge clk);
         chk("stall_no_ack", bus.cl_start_ready, 0);
      end
      @(posedge clk); #1;
      ids = '{0, 0, 5, 0};
      run_end(4'b0100, ids, 1);
      bus.ts_start_ready = 1'b1;
      do_free(5);
      id = lowest_free();
      m_st[id] = 1; m_free--; m_sptr = 2;
      exp_s_cl.push_back(1); exp_s_id.push_back(id);
      it = 0; got = 0;
      while (got == 0 && it < 20) begin
         @(negedge clk);
         got = int'(bus.cl_start_ready[1]);
         it++;
      end
      chk("stall_release_ack", got, 1);
      @(posedge clk); #1;
      bus.cl_start_valid = '0;
      bus.ts_start_ready = 1'b0;
      phase_check();

      for (int p = 0; p < 40; p++) begin
         collect();
         r = $urandom_range(0, 2);
         if (r == 0 && m_free > 0) run_start(pick_set(m_free), 0);
         else if (r == 2 || r == 0) begin
            if ($urandom_range(0, 3) < 3 && ended_q.size() > 0)
               id = ended_q[$urandom_range(0, ended_q.size() - 1)];
            else id = $urandom_range(0, POOL - 1);
            do_free(id);
         end else begin
            for (int k = 0; k < N; k++) begin
               r = $urandom_range(0, 3);
               if (r < 2 && live_q.size() > 0) ids[k] = live_q[$urandom_range(0, live_q.size() - 1)];
               else if (r == 2 && ended_q.size() > 0) ids[k] = ended_q[$urandom_range(0, ended_q.size() - 1)];
               else ids[k] = $urandom_range(0, POOL - 1);
            end
            run_end(4'($urandom_range(1, 15)), ids, 0);
         end
         phase_check();
      end

      apply_reset();
      bus.ts_start_ready = 1'b0;
      bus.cl_start_valid = 4'b0001;
      @(posedge clk); #1;
      @(negedge clk);
      chk("issue_valid", bus.ts_start_valid, 1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_valid", bus.ts_start_valid, 0);
      bus.cl_start_valid = '0;
      model_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_free_cnt", bus.free_cnt, 16);
      chk("post_reset_ts_start_valid", bus.ts_start_valid, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/ts_event_scheduler.md
Name: ts_event_scheduler

Overview:
Front-end controller for the single-port event timestamper. It shares the timestamper's start and end channels between N_CLIENTS requesters using independent round-robin arbiters. It owns the event-ID pool: it allocates a free ID on each start and returns that ID to the client. It frees the ID only when the timestamper's output record for that ID is consumed.

Parameters:
N_CLIENTS, 4, number of requesting clients (2..16)
ID_W, 4, event ID width; pool holds 2**ID_W IDs

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
cl_start_valid  in  N_CLIENTS  per-client start request, held until acked
cl_start_ready  out  N_CLIENTS  per-client start ack, one-cycle pulse
cl_alloc_id  out  ID_W  allocated ID, valid while any cl_start_ready bit is high
cl_end_valid  in  N_CLIENTS  per-client end request, held until acked
cl_end_id  in  N_CLIENTS*ID_W  per-client end ID, slice k for client k
cl_end_ready  out  N_CLIENTS  per-client end ack, one-cycle pulse
ts_start_valid  out  1  start request to timestamper
ts_start_ready  in  1  timestamper start ready
ts_start_id  out  ID_W  start ID
ts_end_valid  out  1  end request to timestamper
ts_end_ready  in  1  timestamper end ready
ts_end_id  out  ID_W  end ID
rec_fire  in  1  timestamper out_valid && out_ready
rec_id  in  ID_W  out_id of the consumed record
free_cnt  out  ID_W+1  number of unallocated IDs
err_sticky  out  3  [0] bad end, [1] double end, [2] bad free; cleared only by reset

Behaviour:
- Per-ID state: alloc, started, ended. Reset: all bits 0, free_cnt = 2**ID_W, every output 0, both round-robin pointers at client 0.
- Start FSM states: S_IDLE, S_ISSUE.
  - In S_IDLE, when any cl_start_valid is set and free_cnt > 0: round-robin grant begins at the client after the last winner.
  - The allocated ID is the lowest-index free ID. Set alloc[id]; latch owner and ID; go to S_ISSUE.
  - In S_ISSUE, ts_start_valid = 1 and ts_start_id = latched ID, both held stable until ts_start_ready.
  - On the handshake: cl_start_ready[owner] pulses combinationally in that cycle, with cl_alloc_id = ID. Set started[id] and return to S_IDLE.
  - Minimum turnaround: 2 cycles per start. Pool empty: no grant, cl_start_ready stays low.
- End FSM states: E_IDLE, E_ISSUE, E_DROP.
  - In E_IDLE, round-robin grant among cl_end_valid, then check the requested ID.
  - If alloc && started && !ended: set ended; go to E_ISSUE (ts_end_valid held until ts_end_ready).
  - If !alloc or !started: go to E_DROP and set err[0].
  - If ended is already set: go to E_DROP and set err[1].
  - E_ISSUE: cl_end_ready[owner] pulses on the ts_end handshake. E_DROP: cl_end_ready[owner] pulses for one cycle and nothing is sent to the timestamper. Both return to E_IDLE.
- Start and end never carry the same ID in the same cycle: end requires started, which is set only after the start handshake completes.
- Free: on rec_fire with alloc[rec_id] && ended[rec_id], clear alloc, started and ended. On rec_fire otherwise, set err[2] and leave state unchanged.
- Allocate and free in the same cycle: free_cnt updates by (+1 − 1) = 0. A freed ID is allocatable in the next cycle, not the same cycle.
- Round-robin pointers advance only on a grant. A client withdrawing a request is illegal (requests must be held until acked).
- Reset asserted mid-operation: all state is cleared immediately, including S_ISSUE/E_ISSUE and ts_*_valid.

Optional Feature:
TS_SCHED_PRIO_EN
- Defined: client 0 has strict priority on both start and end arbiters; the remaining clients are round-robin among themselves.
- Undefined: pure round-robin across all clients, as above.

Test Plan:
- Reset, then client 1 asserts start with ts_start_ready=1 -> ts_start_id=0 one cycle after the request; cl_start_ready[1] pulses with cl_alloc_id=0; free_cnt 16->15.
- Clients 0-3 hold start requests continuously, ts_start_ready=1 -> grants in order 0,1,2,3,0 with IDs 0,1,2,3,4, one grant every 2 cycles.
- Allocate all 16 IDs; a 17th request stalls -> cl_start_ready stays 0. Then drive rec_fire, rec_id=5 after ID 5 has been ended -> next grant has cl_alloc_id=5.
- Client 2 sends end with id=9 (never allocated) -> cl_end_ready[2] pulses, ts_end_valid stays 0, err_sticky=3'b001.
- End id=3 sent twice -> first is forwarded as ts_end_id=3; second is dropped and err_sticky[1] is set. With ts_end_ready held low for 5 cycles, ts_end_valid and ts_end_id stay stable.
- Assert rst_n=0 while in S_ISSUE -> ts_start_valid drops to 0 asynchronously; free_cnt=16 after release.
